mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_ctrl_pkg.sv | 46 ++++
 rtl/mc_alu_dec.sv | 40 ++++
 rtl/mc_controller.sv | 186 ++++++++++++++++++
 tb/tb_mc_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multicycle RISC-V controller.
// Contents: FSM state enum, supported opcodes, ALUOp, ALUControl and
// ImmSrc codes.
// Ports: none (package).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: ALUControl decoder.
// Ports:
//   alu_op      in  2  ALUOp from the controller FSM
//   funct3      in  3  Instr[14:12]
//   op5         in  1  Instr[5] (distinguishes R-type from I-type)
//   funct7b5    in  1  Instr[30]
//   alu_control out 4  ALU operation code
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_ADD;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore-FSM control unit for a multicycle RISC-V datapath.
// Ports:
//   clk, reset                     in   clock, synchronous active-high reset
//   op[6:0], funct3[2:0], funct7b5 in   instruction fields
//   Zero, Con_BGT, Con_BLT         in   ALU flags
//   PCWrite, AdrSrc, MemWrite,
//   IRWrite, RegWrite              out  datapath strobes / selects
//   ResultSrc, ALUSrcA, ALUSrcB    out  2-bit mux selects
//   ImmSrc[2:0]                    out  immediate format (from op only)
//   ALUControl[3:0]                out  ALU operation
//   Illegal                        out  pulses in DECODE on an unsupported op
//   State[3:0]                     out  current state, for debug
// Build option: define MC_CTRL_BRANCH_EXT_EN to add blt/bge/bgt-style
// branches (funct3 100/101/110) using Con_BLT/Con_BGT.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       Con_BGT,
    input  logic       Con_BLT,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t     state, state_next;
    logic [1:0] alu_op;
    logic       branch_taken;
    logic       op_supported;

    always_comb begin
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: op_supported = 1'b1;
            default:                                             op_supported = 1'b0;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000: branch_taken = Zero;
            3'b001: branch_taken = ~Zero;
`ifdef MC_CTRL_BRANCH_EXT_EN
            3'b100: branch_taken = Con_BLT;
            3'b101: branch_taken = ~Con_BLT;
            3'b110: branch_taken = Con_BGT;
`endif
            default: branch_taken = 1'b0;
        endcase
    end

`ifndef MC_CTRL_BRANCH_EXT_EN
    logic unused_flags;
    assign unused_flags = Con_BGT ^ Con_BLT;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECR;
                    OP_ITYPE:     state_next = S_EXECI;
                    OP_BRANCH:    state_next = S_BRANCH;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: state_next = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: state_next = S_ALUWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: state_next = S_FETCH;
            default:   state_next = S_FETCH;
        endcase
    end

    // Output logic; while reset is high the FETCH selects are shown with
    // every strobe held low, regardless of the state still registered.
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = ALUOP_ADD;
        Illegal   = 1'b0;
        State     = state;
        if (reset) begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            State     = S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    PCWrite   = 1'b1;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    Illegal = ~op_supported;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD: AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = 2'b10;
                    alu_op  = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    alu_op  = ALUOP_FUNCT;
                end
                S_ALUWB: RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA = 2'b10;
                    alu_op  = ALUOP_SUB;
                    PCWrite = branch_taken;
                end
                S_JAL: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (op)
            OP_SW:     ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            default:   ImmSrc = IMM_I;
        endcase
    end

    mc_alu_dec u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed self-checking bench for mc_controller.
// Honours MC_CTRL_BRANCH_EXT_EN for the extended-branch expectation.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero, Con_BGT, Con_BLT;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       Illegal;
    logic [3:0] State;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .Con_BGT    (Con_BGT),
        .Con_BLT    (Con_BLT),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .Illegal    (Illegal),
        .State      (State)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobes packed as {PCWrite, IRWrite, MemWrite, RegWrite, Illegal}
    function automatic logic [4:0] strobes();
        return {PCWrite, IRWrite, MemWrite, RegWrite, Illegal};
    endfunction

    // Drive an instruction from FETCH and step to DECODE.
    task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
        #1;
        check("fetch_state", State, 4'd0);
        check("fetch_strobes", strobes(), 5'b11000);
        tick();
        check("decode_state", State, 4'd1);
    endtask

    task automatic run_r(input logic [2:0] f3, input logic f7, input logic [3:0] exp_ctl);
        issue(7'b0110011, f3, f7);
        tick();
        check("execr_state", State, 4'd6);
        check("execr_aluctl", ALUControl, exp_ctl);
        tick();
        check("aluwb_regwrite", {State, RegWrite}, {4'd8, 1'b1});
        tick();
    endtask

    task automatic run_branch(input logic [2:0] f3, input logic z, input logic blt,
                              input logic exp_pc, input string tag);
        Zero = z; Con_BLT = blt;
        issue(7'b1100011, f3, 1'b0);
        check("branch_imm", ImmSrc, 3'b010);
        tick();
        check("branch_state", State, 4'd9);
        check(tag, PCWrite, exp_pc);
        check("branch_aluctl", ALUControl, 4'b0001);
        tick();
        check("branch_next", State, 4'd0);
        Zero = 1'b0; Con_BLT = 1'b0;
    endtask

    logic [2:0] r_f3  [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [3:0] r_ctl [8] = '{4'b0000, 4'b0110, 4'b0101, 4'b0000, 4'b0100, 4'b0111, 4'b0011, 4'b0010};

    initial begin
        reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0;
        Zero = 1'b0; Con_BGT = 1'b0; Con_BLT = 1'b0;
        tick(); tick();
        check("rst_state", State, 4'd0);
        check("rst_strobes", strobes(), 5'b00000);
        check("rst_selects", {ResultSrc, ALUSrcA, ALUSrcB}, 6'b10_00_10);
        reset = 1'b0;
        #1;

        // lw: 0,1,2,3,4,0
        issue(7'b0000011, 3'b010, 1'b0);
        check("lw_decode_src", {ALUSrcA, ALUSrcB}, 4'b01_01);
        check("lw_imm", ImmSrc, 3'b000);
        tick(); check("lw_memadr", {State, ALUSrcA, ALUSrcB}, {4'd2, 4'b10_01});
        tick(); check("lw_memread", {State, AdrSrc, RegWrite}, {4'd3, 2'b10});
        tick(); check("lw_memwb", {State, RegWrite, ResultSrc}, {4'd4, 3'b101});
        tick(); check("lw_done", State, 4'd0);

        // sw
        issue(7'b0100011, 3'b010, 1'b0);
        check("sw_imm", ImmSrc, 3'b001);
        tick(); check("sw_memadr", State, 4'd2);
        tick(); check("sw_memwrite", {State, MemWrite, AdrSrc, RegWrite}, {4'd5, 3'b110});
        tick(); check("sw_done", State, 4'd0);

        // R-type sub and full funct3 table
        run_r(3'b000, 1'b1, 4'b0001);
        for (int i = 0; i < 8; i++) run_r(r_f3[i], 1'b0, r_ctl[i]);

        // I-type addi with funct7b5 set is still add
        issue(7'b0010011, 3'b000, 1'b1);
        tick();
        check("execi_state", {State, ALUSrcA, ALUSrcB}, {4'd7, 4'b10_01});
        check("execi_aluctl", ALUControl, 4'b0000);
        tick(); check("execi_aluwb", {State, RegWrite}, {4'd8, 1'b1});
        tick();

        // Branches
        run_branch(3'b000, 1'b1, 1'b0, 1'b1, "beq_taken");
        run_branch(3'b000, 1'b0, 1'b0, 1'b0, "beq_not_taken");
        run_branch(3'b001, 1'b0, 1'b0, 1'b1, "bne_taken");
        run_branch(3'b001, 1'b1, 1'b0, 1'b0, "bne_not_taken");
`ifdef MC_CTRL_BRANCH_EXT_EN
        run_branch(3'b100, 1'b0, 1'b1, 1'b1, "blt_ext");
`else
        run_branch(3'b100, 1'b0, 1'b1, 1'b0, "blt_ext");
`endif

        // jal
        issue(7'b1101111, 3'b000, 1'b0);
        check("jal_imm", ImmSrc, 3'b011);
        tick();
        check("jal_state", {State, PCWrite, ALUSrcA, ALUSrcB}, {4'd10, 1'b1, 4'b01_10});
        tick(); check("jal_aluwb", {State, RegWrite}, {4'd8, 1'b1});
        tick(); check("jal_done", State, 4'd0);

        // Illegal opcode
        issue(7'b1111111, 3'b000, 1'b0);
        check("illegal_decode", strobes(), 5'b00001);
        tick();
        check("illegal_back", State, 4'd0);
        check("illegal_fetch", Illegal, 1'b0);

        // Reset held 3 cycles mid-EXECR
        issue(7'b0110011, 3'b000, 1'b0);
        tick();
        check("pre_reset_state", State, 4'd6);
        reset = 1'b1;
        #1;
        check("reset_async_view", {State, strobes()}, {4'd0, 5'b00000});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", {State, strobes()}, {4'd0, 5'b00000});
        end
        reset = 1'b0;
        #1;
        check("post_reset", {State, PCWrite, IRWrite}, {4'd0, 2'b11});
        tick();
        check("post_reset_decode", State, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
